// File: rtl/egress_arbiter_if.sv
// ============================================================================
// Module      : egress_arbiter_if
// Description : Bundles the VC FIFO read side and the egress FIFO write side
//               of the egress arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface egress_arbiter_if #(
   parameter int DATA_WIDTH = 12
);
   logic [3:0]            state;
   logic                  empty_0;
   logic                  empty_1;
   logic                  empty_2;
   logic                  empty_3;
   logic [DATA_WIDTH-1:0] data_in_0;
   logic [DATA_WIDTH-1:0] data_in_1;
   logic [DATA_WIDTH-1:0] data_in_2;
   logic [DATA_WIDTH-1:0] data_in_3;
   logic                  almost_full_out;
   logic                  pop_0;
   logic                  pop_1;
   logic                  pop_2;
   logic                  pop_3;
   logic [1:0]            grant;
   logic                  push_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  idle_out;

   // Environment side: FIFOs and link state controller
   modport master (
      output state, empty_0, empty_1, empty_2, empty_3,
             data_in_0, data_in_1, data_in_2, data_in_3, almost_full_out,
      input  pop_0, pop_1, pop_2, pop_3, grant, push_out, data_out, idle_out
   );

   // Arbiter side
   modport slave (
      input  state, empty_0, empty_1, empty_2, empty_3,
             data_in_0, data_in_1, data_in_2, data_in_3, almost_full_out,
      output pop_0, pop_1, pop_2, pop_3, grant, push_out, data_out, idle_out
   );
endinterface

`default_nettype wire

// File: rtl/egress_arbiter.sv
// ============================================================================
// Module      : egress_arbiter
// Description : Round-robin scheduler draining four VC FIFOs into the egress
//               FIFO, one pop per cycle, fixed 2-cycle pop-to-push latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module egress_arbiter #(
   parameter int DATA_WIDTH = 12
) (
   input  wire logic        clk,
   input  wire logic        reset_L,
   egress_arbiter_if.slave  bus
);

   localparam logic [3:0] c_st_reset  = 4'b0001;
   localparam logic [3:0] c_st_idle   = 4'b0100;
   localparam logic [3:0] c_st_active = 4'b1000;

   logic [3:0]            w_empty;
   logic [3:0]            w_elig;
   logic [3:0]            w_rot;
   logic                  w_enable;
   logic                  w_clear;
   logic                  w_found;
   logic                  w_decide;
   logic [1:0]            w_ofs;
   logic [1:0]            w_win;
   logic [DATA_WIDTH-1:0] w_data_sel;

   logic [3:0]            r_pop;
   logic [1:0]            r_grant;
   logic [1:0]            r_ptr;
   logic                  r_last_valid;
   logic [1:0]            r_last_vc;
   logic                  r_s2_valid;
   logic [1:0]            r_s2_vc;
   logic                  r_push;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_idle;

   assign w_empty  = {bus.empty_3, bus.empty_2, bus.empty_1, bus.empty_0};
   assign w_enable = (bus.state == c_st_idle) || (bus.state == c_st_active);
   assign w_clear  = (bus.state == c_st_reset);

   // The VC being popped right now still shows its old empty flag, so mask it
   assign w_elig = ~w_empty & ~r_pop;

   // Rotate eligibility so that bit 0 is the VC at the pointer
   for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign w_rot[gi] = w_elig[r_ptr + 2'(gi)];
   end

   always_comb begin
      w_found = 1'b0;
      w_ofs   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_found = 1'b1;
            w_ofs   = 2'(i);
         end
      end
   end

   assign w_win    = r_ptr + w_ofs;
   assign w_decide = w_enable && !bus.almost_full_out && w_found;

   always_comb begin
      w_data_sel = bus.data_in_0;
      case (r_s2_vc)
         2'd1:    w_data_sel = bus.data_in_1;
         2'd2:    w_data_sel = bus.data_in_2;
         2'd3:    w_data_sel = bus.data_in_3;
         default: w_data_sel = bus.data_in_0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_pop        <= 4'd0;
         r_grant      <= 2'd0;
         r_ptr        <= 2'd0;
         r_last_valid <= 1'b0;
         r_last_vc    <= 2'd0;
         r_s2_valid   <= 1'b0;
         r_s2_vc      <= 2'd0;
         r_push       <= 1'b0;
         r_data       <= '0;
         r_idle       <= 1'b0;
      end else if (w_clear) begin
         r_pop        <= 4'd0;
         r_grant      <= 2'd0;
         r_ptr        <= 2'd0;
         r_last_valid <= 1'b0;
         r_last_vc    <= 2'd0;
         r_s2_valid   <= 1'b0;
         r_s2_vc      <= 2'd0;
         r_push       <= 1'b0;
         r_data       <= '0;
         r_idle       <= 1'b0;
      end else begin
         r_pop        <= w_decide ? (4'b0001 << w_win) : 4'b0000;
         r_grant      <= w_decide ? w_win : 2'd0;
         if (w_decide) begin
            r_ptr <= w_win + 2'd1;
         end
         r_last_valid <= w_decide;
         r_last_vc    <= w_win;
         // Read data for stage 2 is on data_in_k by the time it is captured
         r_s2_valid   <= r_last_valid;
         r_s2_vc      <= r_last_vc;
         r_push       <= r_s2_valid;
         if (r_s2_valid) begin
            r_data <= w_data_sel;
         end
         r_idle       <= w_enable && (&w_empty) && !w_decide
                         && !r_last_valid && !r_s2_valid;
      end
   end

   assign bus.pop_0    = r_pop[0];
   assign bus.pop_1    = r_pop[1];
   assign bus.pop_2    = r_pop[2];
   assign bus.pop_3    = r_pop[3];
   assign bus.grant    = r_grant;
   assign bus.push_out = r_push;
   assign bus.data_out = r_data;
   assign bus.idle_out = r_idle;

endmodule

`default_nettype wire

// File: tb/tb_egress_arbiter.sv
// ============================================================================
// Module      : tb_egress_arbiter
// Description : Directed and random checks of egress_arbiter against a
//               queue-based scheduling model with behavioural VC FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_egress_arbiter;

   logic clk = 1'b0;
   logic reset_L;

   always #5 clk = ~clk;

   egress_arbiter_if #(.DATA_WIDTH(12)) bus ();

   egress_arbiter #(.DATA_WIDTH(12)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   typedef struct {
      int         due;
      logic [11:0] word;
   } pend_t;

   logic [11:0] q [4][$];
   logic [11:0] rdata [4];
   pend_t       pend [$];

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          m_ptr    = 0;
   int          m_last   = -1;
   logic [3:0]  e_pop;
   logic [1:0]  e_grant;
   logic        e_push;
   logic [11:0] e_data;
   logic        e_idle;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifos();
      bus.empty_0   = (q[0].size() == 0);
      bus.empty_1   = (q[1].size() == 0);
      bus.empty_2   = (q[2].size() == 0);
      bus.empty_3   = (q[3].size() == 0);
      bus.data_in_0 = rdata[0];
      bus.data_in_1 = rdata[1];
      bus.data_in_2 = rdata[2];
      bus.data_in_3 = rdata[3];
   endtask

   task automatic load(input int k, input logic [11:0] w);
      q[k].push_back(w);
      drive_fifos();
   endtask

   task automatic model_reset();
      m_ptr = 0; m_last = -1; pend.delete();
      e_pop = 4'd0; e_grant = 2'd0; e_push = 1'b0; e_data = 12'd0; e_idle = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_pop"},   {bus.pop_3, bus.pop_2, bus.pop_1, bus.pop_0}, e_pop);
      check({tag, "_grant"}, bus.grant, e_grant);
      check({tag, "_push"},  bus.push_out, e_push);
      check({tag, "_data"},  bus.data_out, e_data);
      check({tag, "_idle"},  bus.idle_out, e_idle);
   endtask

   // One clock: predict from the inputs present before the edge, then compare
   task automatic step();
      logic [3:0] popcur;
      bit         en, clr, allempty;
      int         win;
      popcur   = {bus.pop_3, bus.pop_2, bus.pop_1, bus.pop_0};
      clr      = (bus.state == 4'b0001);
      en       = (bus.state == 4'b0100) || (bus.state == 4'b1000);
      allempty = (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0) && (q[3].size() == 0);
      win      = -1;
      if (en && !bus.almost_full_out) begin
         for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_ptr + i) % 4;
            if (win < 0 && q[k].size() > 0 && k != m_last) win = k;
         end
      end
      if (!reset_L || clr) begin
         model_reset();
      end else begin
         e_idle = en && allempty && (win < 0) && (pend.size() == 0);
         e_push = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            e_push = 1'b1;
            e_data = pend[0].word;
            void'(pend.pop_front());
         end
         if (win >= 0) begin
            pend.push_back('{cyc + 2, q[win][0]});
            e_pop   = 4'b0001 << win;
            e_grant = 2'(win);
            m_ptr   = (win + 1) % 4;
            m_last  = win;
         end else begin
            e_pop   = 4'd0;
            e_grant = 2'd0;
            m_last  = -1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check_outputs("step");
      for (int k = 0; k < 4; k++) begin
         if (popcur[k] && q[k].size() > 0) rdata[k] = q[k].pop_front();
      end
      drive_fifos();
   endtask

   task automatic drain();
      int n;
      bus.state = 4'b1000;
      bus.almost_full_out = 1'b0;
      n = 0;
      while (!((q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0)
               && (q[3].size() == 0) && pend.size() == 0 && m_last < 0) && n < 64) begin
         step();
         n++;
      end
      check("drain_bound", (n < 64), 1);
   endtask

   task automatic async_reset_check();
      #3 reset_L = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
   endtask

   initial begin
      int pushes;
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushes;
      reset_L = 1'b0;
      bus.state = 4'b0001;
      bus.almost_full_out = 1'b0;
      for (int k = 0; k < 4; k++) rdata[k] = 12'd0;
      drive_fifos();
      model_reset();
      #1;
      check_outputs("reset");
      step(); step();
      #3 reset_L = 1'b1;
      bus.state = 4'b1000;
      step(); step();
      check("idle_after_reset", bus.idle_out, 1);

      // Single non-empty VC: pop every other cycle
      load(1, 12'h0A1); load(1, 12'h0A2); load(1, 12'h0A3);
      for (int i = 0; i < 7; i++) begin
         step();
         check("sv_pop1", bus.pop_1, (i == 0 || i == 2 || i == 4));
         check("sv_push", bus.push_out, (i == 2 || i == 4 || i == 6));
         if (i == 2 || i == 4 || i == 6) check("sv_data", bus.data_out, 12'h0A0 + 12'(i / 2));
      end
      drain();

      // Full round-robin from pointer 0
      bus.state = 4'b0001; step();
      bus.state = 4'b1000;
      for (int k = 0; k < 4; k++) begin
         load(k, 12'(16 * k + 1)); load(k, 12'(16 * k + 2));
      end
      for (int i = 0; i < 10; i++) begin
         step();
         check("rr_grant", bus.grant, (i < 8) ? (i % 4) : 0);
         check("rr_push", bus.push_out, (i >= 2));
      end
      drain();

      // Pointer continues after VC2
      load(2, 12'h222); step();
      check("pc_grant2", bus.grant, 2);
      drain();
      load(0, 12'h300); load(3, 12'h333);
      step(); check("pc_grant3", bus.grant, 3);
      step(); check("pc_grant0", bus.grant, 0);
      drain();

      // Back-pressure with two pops in flight
      load(0, 12'h401); load(0, 12'h402); load(1, 12'h411); load(1, 12'h412);
      step(); step();
      bus.almost_full_out = 1'b1;
      pushes = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_no_pop", {bus.pop_3, bus.pop_2, bus.pop_1, bus.pop_0}, 0);
         if (bus.push_out) pushes++;
      end
      check("bp_push_count", pushes, 2);
      bus.almost_full_out = 1'b0;
      drain();

      // Clear one cycle after a pop
      load(0, 12'h501); load(0, 12'h502); load(2, 12'h521); load(2, 12'h522);
      step();
      bus.state = 4'b0001; step();
      bus.state = 4'b0001; step();
      check("clr_push", bus.push_out, 0);
      bus.state = 4'b1000; step();
      check("clr_grant0", bus.grant, 0);
      check("clr_pop0", bus.pop_0, 1);
      drain();

      // Random traffic, back-pressure, state changes and one async reset
      for (int i = 0; i < 1500; i++) begin
         int r;
         if ($urandom_range(3) == 0) begin
            int k;
            k = $urandom_range(3);
            if (q[k].size() < 8) load(k, 12'($urandom));
         end
         bus.almost_full_out = ($urandom_range(4) == 0);
         r = $urandom_range(31);
         case (r)
            0:       bus.state = 4'b0001;
            1:       bus.state = 4'b0010;
            2:       bus.state = 4'b0100;
            3:       bus.state = 4'($urandom);
            default: bus.state = 4'b1000;
         endcase
         if (i == 700) begin
            async_reset_check();
            step();
            #3 reset_L = 1'b1;
         end
         step();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
